// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - request/response bundle between the stage-3 access port and the data memory
interface dmem_if #(
  parameter int AW = 32
);
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [1:0]    req_size_i;
  logic          req_unsigned_i;
  logic [AW-1:0] req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-organised data SRAM with byte-lane stores, extended loads
// and two-cycle handling of accesses that straddle a word boundary
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-2:0] DEPTH_L = (AW-1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;
  state_t state;

  logic [31:0] mem [DEPTH];

  logic          r_we, r_uns;
  logic [1:0]    r_size, r_off;
  logic [IW-1:0] r_hi_idx;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_wd_hi, lo_q;

  logic [1:0]    off;
  logic [3:0]    size_mask;
  logic [7:0]    be8;
  logic [63:0]   wd64;
  logic          misaligned, req_err, accept;
  logic [AW-2:0] lo_ext, hi_ext;
  logic [IW-1:0] lo_idx, hi_idx, rd_idx, wr_idx;
  logic [31:0]   rd_word, wr_data;
  logic [3:0]    wr_be;
  logic          wr_en;

  assign off = bus.req_addr_i[1:0];

  always_comb begin
    size_mask = 4'b0000;
    case (bus.req_size_i)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      2'd2:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  // Lanes 7..4 belong to the next word; any of them set means a straddling access.
  assign be8        = {4'b0000, size_mask} << off;
  assign wd64       = {32'b0, bus.req_wdata_i} << {off, 3'b000};
  assign misaligned = |be8[7:4];

  assign lo_ext  = {1'b0, bus.req_addr_i[AW-1:2]};
  assign hi_ext  = lo_ext + 1'b1;
  assign req_err = (bus.req_size_i == 2'd3) || (lo_ext >= DEPTH_L) ||
                   (misaligned && (hi_ext >= DEPTH_L));

  assign lo_idx = bus.req_addr_i[IW+1:2];
  assign hi_idx = lo_idx + 1'b1;

  assign bus.req_ready_o = (state == IDLE) && !rst;
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  assign rd_idx  = (state == IDLE) ? lo_idx : r_hi_idx;
  assign rd_word = mem[rd_idx];

  // Second-half store is dropped if reset lands in SECOND.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = lo_idx;
    wr_be   = be8[3:0];
    wr_data = wd64[31:0];
    if (accept && bus.req_we_i && !req_err) begin
      wr_en = 1'b1;
    end else if (state == SECOND && r_we && !rst) begin
      wr_en   = 1'b1;
      wr_idx  = r_hi_idx;
      wr_be   = r_be_hi;
      wr_data = r_wd_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic uns);
    case (size)
      2'd0:    return {{24{v[7] & ~uns}}, v[7:0]};
      2'd1:    return {{16{v[15] & ~uns}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      bus.resp_valid_o <= 1'b0;
      bus.resp_rdata_o <= 32'b0;
      bus.resp_err_o   <= 1'b0;
      r_we             <= 1'b0;
      r_uns            <= 1'b0;
      r_size           <= 2'd0;
      r_off            <= 2'd0;
      r_hi_idx         <= '0;
      r_be_hi          <= 4'b0;
      r_wd_hi          <= 32'b0;
      lo_q             <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.resp_valid_o <= 1'b0;
          if (accept) begin
            r_we     <= bus.req_we_i;
            r_uns    <= bus.req_unsigned_i;
            r_size   <= bus.req_size_i;
            r_off    <= off;
            r_hi_idx <= hi_idx;
            r_be_hi  <= be8[7:4];
            r_wd_hi  <= wd64[63:32];
            lo_q     <= rd_word;
            if (req_err) begin
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b1;
              bus.resp_rdata_o <= 32'b0;
              state            <= RESP;
            end else if (misaligned) begin
              state <= SECOND;
            end else begin
              bus.resp_valid_o <= 1'b1;
              bus.resp_err_o   <= 1'b0;
              bus.resp_rdata_o <= bus.req_we_i ? 32'b0 :
                  extend(rd_word >> {off, 3'b000}, bus.req_size_i, bus.req_unsigned_i);
              state            <= RESP;
            end
          end
        end
        SECOND: begin
          bus.resp_valid_o <= 1'b1;
          bus.resp_err_o   <= 1'b0;
          bus.resp_rdata_o <= r_we ? 32'b0 :
              extend(32'({rd_word, lo_q} >> {r_off, 3'b000}), r_size, r_uns);
          state            <= RESP;
        end
        RESP: begin
          bus.resp_valid_o <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if #(.AW(32)) bus ();
  dmem_responder #(.DEPTH(1024), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } op_t;

  exp_t exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat,
                      output logic rdy_resp);
    int waited = 0;
    lat = -1; rdata = 'x; err = 'x; rdy_resp = 'x;
    @(negedge clk);
    while (!bus.req_ready_o && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready_o) return;
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = size;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = $urandom_range(0, 1);
    bus.req_size_i     = 2'($urandom_range(0, 3));
    bus.req_unsigned_i = $urandom_range(0, 1);
    bus.req_addr_i     = $urandom;
    bus.req_wdata_i    = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid_o) begin
        lat      = c;
        rdata    = bus.resp_rdata_o;
        err      = bus.resp_err_o;
        rdy_resp = bus.req_ready_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", bus.req_ready_o); end
    n_cmp++; if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.resp_valid_o); end
    n_cmp++; if (bus.resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus.resp_rdata_o); end
    n_cmp++; if (bus.resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.resp_err_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", bus.req_ready_o); end
  endtask

  task automatic test_aligned();
    op_t ops[$];
    logic [31:0] rd; logic er, rr; int lt; exp_t e;
    ops.push_back('{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1});
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].rdata, ops[i].err, ops[i].lat});
      xfer(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, rd, er, lt, rr);
      e = exp_q.pop_front();
      n_cmp++; if (lt !== e.lat) begin n_fail++; $display("FAIL aligned[%0d] latency got %0d want %0d", i, lt, e.lat); end
      n_cmp++; if (er !== e.err) begin n_fail++; $display("FAIL aligned[%0d] err got %b want %b", i, er, e.err); end
      n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL aligned[%0d] rdata got %h want %h", i, rd, e.rdata); end
      n_cmp++; if (rr !== 1'b0) begin n_fail++; $display("FAIL aligned[%0d] ready_in_resp got %b want 0", i, rr); end
    end
  endtask

  task automatic test_subword();
    op_t ops[$];
    logic [31:0] rd; logic er, rr; int lt; exp_t e;
    ops.push_back('{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 1});
    ops.push_back('{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1});
    ops.push_back('{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1});
    ops.push_back('{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 1});
    ops.push_back('{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 1});
    ops.push_back('{1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'hFFFFADBE, 1'b0, 1});
    ops.push_back('{1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1});
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].rdata, ops[i].err, ops[i].lat});
      xfer(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, rd, er, lt, rr);
      e = exp_q.pop_front();
      n_cmp++; if (lt !== e.lat) begin n_fail++; $display("FAIL subword[%0d] latency got %0d want %0d", i, lt, e.lat); end
      n_cmp++; if (er !== e.err) begin n_fail++; $display("FAIL subword[%0d] err got %b want %b", i, er, e.err); end
      n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL subword[%0d] rdata got %h want %h", i, rd, e.rdata); end
    end
  endtask

  task automatic test_lanes();
    op_t ops[$];
    logic [31:0] rd; logic er, rr; int lt; exp_t e;
    ops.push_back('{1'b1, 2'd2, 1'b0, 32'h14, 32'h00000000, 32'h0, 1'b0, 1});
    ops.push_back('{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 1});
    ops.push_back('{1'b1, 2'd1, 1'b0, 32'h16, 32'hABCD1234, 32'h0, 1'b0, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'h12340000, 1'b0, 1});
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].rdata, ops[i].err, ops[i].lat});
      xfer(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, rd, er, lt, rr);
      e = exp_q.pop_front();
      n_cmp++; if (lt !== e.lat) begin n_fail++; $display("FAIL lanes[%0d] latency got %0d want %0d", i, lt, e.lat); end
      n_cmp++; if (er !== e.err) begin n_fail++; $display("FAIL lanes[%0d] err got %b want %b", i, er, e.err); end
      n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL lanes[%0d] rdata got %h want %h", i, rd, e.rdata); end
    end
  endtask

  task automatic test_misaligned();
    op_t ops[$];
    logic [31:0] rd; logic er, rr; int lt; exp_t e;
    ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0C, 32'hAABBCCDD, 32'h0, 1'b0, 1});
    ops.push_back('{1'b1, 2'd2, 1'b0, 32'h0E, 32'h11223344, 32'h0, 1'b0, 2});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 32'h11223344, 1'b0, 2});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 32'h3344CCDD, 1'b0, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD1122, 1'b0, 1});
    ops.push_back('{1'b0, 2'd1, 1'b0, 32'h0F, 32'h0, 32'h00002233, 1'b0, 2});
    ops.push_back('{1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 32'h000000DE, 1'b0, 2});
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].rdata, ops[i].err, ops[i].lat});
      xfer(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, rd, er, lt, rr);
      e = exp_q.pop_front();
      n_cmp++; if (lt !== e.lat) begin n_fail++; $display("FAIL misaligned[%0d] latency got %0d want %0d", i, lt, e.lat); end
      n_cmp++; if (er !== e.err) begin n_fail++; $display("FAIL misaligned[%0d] err got %b want %b", i, er, e.err); end
      n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL misaligned[%0d] rdata got %h want %h", i, rd, e.rdata); end
    end
  endtask

  task automatic test_errors();
    op_t ops[$];
    logic [31:0] rd; logic er, rr; int lt; exp_t e;
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1});
    ops.push_back('{1'b1, 2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, 1});
    ops.push_back('{1'b1, 2'd2, 1'b0, 32'hFFE, 32'h12345678, 32'h0, 1'b1, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0, 1});
    ops.push_back('{1'b0, 2'd1, 1'b0, 32'hFFF, 32'h0, 32'h0, 1'b1, 1});
    ops.push_back('{1'b0, 2'd0, 1'b0, 32'hFFF, 32'h0, 32'hFFFFFFCA, 1'b0, 1});
    ops.push_back('{1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1});
    ops.push_back('{1'b1, 2'd3, 1'b0, 32'h10, 32'h99999999, 32'h0, 1'b1, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD1122, 1'b0, 1});
    ops.push_back('{1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0, 32'h0, 1'b1, 1});
    foreach (ops[i]) begin
      exp_q.push_back('{ops[i].rdata, ops[i].err, ops[i].lat});
      xfer(ops[i].we, ops[i].size, ops[i].uns, ops[i].addr, ops[i].wdata, rd, er, lt, rr);
      e = exp_q.pop_front();
      n_cmp++; if (lt !== e.lat) begin n_fail++; $display("FAIL errors[%0d] latency got %0d want %0d", i, lt, e.lat); end
      n_cmp++; if (er !== e.err) begin n_fail++; $display("FAIL errors[%0d] err got %b want %b", i, er, e.err); end
      n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL errors[%0d] rdata got %h want %h", i, rd, e.rdata); end
    end
  endtask

  task automatic test_random();
    logic [7:0] mm [int];
    logic [31:0] rd, addr, wdata, v; logic er, rr, we, uns; logic [1:0] size;
    int lt, nb; exp_t e;
    for (int k = 0; k < 56; k++) begin
      if (k < 16) begin
        we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h200 + 32'(4 * k);
      end else begin
        we = $urandom_range(0, 1); size = 2'($urandom_range(0, 2)); uns = $urandom_range(0, 1);
        addr = 32'h200 + $urandom_range(0, 32'h38);
      end
      wdata = $urandom;
      nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      v = 32'h0;
      if (we) begin
        for (int b = 0; b < nb; b++) mm[int'(addr) + b] = wdata[8*b +: 8];
      end else begin
        for (int b = 0; b < nb; b++) v[8*b +: 8] = mm[int'(addr) + b];
        if (nb < 4 && !uns && v[8*nb-1]) for (int b = nb; b < 4; b++) v[8*b +: 8] = 8'hFF;
      end
      exp_q.push_back('{v, 1'b0, (int'(addr[1:0]) + nb > 4) ? 2 : 1});
      xfer(we, size, uns, addr, wdata, rd, er, lt, rr);
      e = exp_q.pop_front();
      n_cmp++; if (lt !== e.lat) begin n_fail++; $display("FAIL random[%0d] latency got %0d want %0d", k, lt, e.lat); end
      n_cmp++; if (er !== e.err) begin n_fail++; $display("FAIL random[%0d] err got %b want %b", k, er, e.err); end
      n_cmp++; if (rd !== e.rdata) begin n_fail++; $display("FAIL random[%0d] rdata got %h want %h", k, rd, e.rdata); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, rr; int lt;
    xfer(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lt, rr);
    xfer(1'b1, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lt, rr);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h22; bus.req_wdata_i = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_second_valid got %b want 0", bus.resp_valid_o); end
    @(negedge clk);
    n_cmp++; if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_reset_valid got %b want 0", bus.resp_valid_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", bus.req_ready_o); end
    @(negedge clk);
    n_cmp++; if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_after_valid got %b want 0", bus.resp_valid_o); end
    exp_q.push_back('{32'hC3D40000, 1'b0, 1});
    xfer(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lt, rr);
    n_cmp++; if (rd !== exp_q[0].rdata || lt !== exp_q[0].lat) begin n_fail++; $display("FAIL rstmid_low_word got %h lat %0d want %h lat %0d", rd, lt, exp_q[0].rdata, exp_q[0].lat); end
    void'(exp_q.pop_front());
    exp_q.push_back('{32'h00000000, 1'b0, 1});
    xfer(1'b0, 2'd2, 1'b0, 32'h24, 32'h0, rd, er, lt, rr);
    n_cmp++; if (rd !== exp_q[0].rdata || lt !== exp_q[0].lat) begin n_fail++; $display("FAIL rstmid_high_word got %h lat %0d want %h lat %0d", rd, lt, exp_q[0].rdata, exp_q[0].lat); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
    test_reset();
    test_aligned();
    test_subword();
    test_lanes();
    test_misaligned();
    test_errors();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
